// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer.
//   Lookup is combinational on cpc. Resolved-branch updates from the execute
//   stage commit on the next rising edge. A same-cycle lookup always sees the
//   pre-update contents because there is no bypass path.
// Ports:
//   CLK         clock; all state changes on the rising edge
//   nRST        synchronous reset, active-high: clears valid bits, ctr <= 2'b01
//   cpc         fetch PC to look up
//   phit        predict taken: entry hit and ctr msb set
//   baddr       stored target on a hit, 32'h0 on a miss
//   flush       clears all valid bits; beats a concurrent update
//   upd_en      resolved-branch update strobe
//   upd_pc      resolved branch PC
//   upd_taken   resolved direction (1 = taken)
//   upd_target  resolved target address
module branch_target_buffer #(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] cpc,
  output logic        phit,
  output logic [31:0] baddr,
  input  logic        flush,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t ent [ENTRIES];

  // pc[1:0] is ignored: instructions are word aligned.
  logic unused_lowbits;
  assign unused_lowbits = ^{cpc[1:0], upd_pc[1:0]};

  // Lookup
  logic [IDX_W-1:0] cidx;
  logic [TAG_W-1:0] ctag;
  logic             cmatch;

  assign cidx = cpc[IDX_W+1:2];
  assign ctag = cpc[31:IDX_W+2];

  // valid is always known after reset, so a cleared entry forces a clean
  // miss even though its tag/target are still X.
  always_comb begin
    cmatch = 1'b0;
    if (ent[cidx].valid) cmatch = (ent[cidx].tag == ctag);
  end

  assign phit  = cmatch & ent[cidx].ctr[1];
  assign baddr = cmatch ? ent[cidx].target : 32'h0;

  // Update
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             umatch;
  logic [1:0]       uctr;

  assign uidx = upd_pc[IDX_W+1:2];
  assign utag = upd_pc[31:IDX_W+2];
  assign uctr = ent[uidx].ctr;

  always_comb begin
    umatch = 1'b0;
    if (ent[uidx].valid) umatch = (ent[uidx].tag == utag);
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].ctr   <= 2'b01;
      end
    end else if (flush) begin
      // ctr/target are left as-is; only validity matters for a miss.
      for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
    end else if (upd_en) begin
      if (umatch) begin
        if (upd_taken) begin
          ent[uidx].ctr    <= (uctr == 2'b11) ? 2'b11 : uctr + 2'd1;
          ent[uidx].target <= upd_target;
        end else begin
          ent[uidx].ctr    <= (uctr == 2'b00) ? 2'b00 : uctr - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate (evicting any alias) weakly taken.
        ent[uidx].valid  <= 1'b1;
        ent[uidx].tag    <= utag;
        ent[uidx].target <= upd_target;
        ent[uidx].ctr    <= 2'b10;
      end
    end
  end
endmodule
